// File: rtl/vsfx_vsubs_pipe_pkg.sv
// Shared definitions for the VSFX saturating vector subtract pipeline:
// element-size encodings, the signed-select bit, default widths and clamp limits.
package vsfx_pkg;

  localparam int VLEN_DEF = 128;
  localparam int OPW_DEF  = 3;

  // op[1:0] element size; 2'b11 is reserved and runs as word.
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  localparam int SGN_BIT = 2;

  localparam logic [7:0]  S8_MAX  = 8'h7F;
  localparam logic [7:0]  S8_MIN  = 8'h80;
  localparam logic [15:0] S16_MAX = 16'h7FFF;
  localparam logic [15:0] S16_MIN = 16'h8000;
  localparam logic [31:0] S32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] S32_MIN = 32'h8000_0000;

endpackage

// File: rtl/vsfx_vsubs_pipe_if.sv
// Issue-side request and writeback-side result bundle of the VSFX subtract unit.
// Valid/ready: a beat moves on a rising edge where valid && ready; the sender
// holds its payload stable while valid=1 and ready=0.
interface vsfx_vsubs_pipe_if
  import vsfx_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int OPW  = OPW_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic [VLEN-1:0] vra;
  logic [VLEN-1:0] vrb;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vrt;
  logic            sat;

  modport master (
    output in_valid, op, vra, vrb, out_ready,
    input  in_ready, out_valid, vrt, sat
  );

  modport slave (
    input  in_valid, op, vra, vrb, out_ready,
    output in_ready, out_valid, vrt, sat
  );
endinterface

// File: rtl/vsfx_vsubs_pipe_sat_lane.sv
// One 32-bit lane of saturating subtract a - b, as 4 bytes, 2 halves or 1 word.
// Produces the clamped result and one saturation flag per byte position.
module vsfx_sat_sub_lane
  import vsfx_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] res,
  output logic [3:0]  sat_b
);
  logic [8:0]  d8  [4];
  logic [16:0] d16 [2];
  logic [32:0] d32;
  logic [31:0] r8, r16, r32;
  logic [3:0]  s8;
  logic [1:0]  s16;
  logic        s32;

  // Raw differences carry one extra bit; its MSB is the unsigned borrow.
  always_comb begin
    for (int k = 0; k < 4; k++) d8[k]  = {1'b0, a[8*k +: 8]}   - {1'b0, b[8*k +: 8]};
    for (int k = 0; k < 2; k++) d16[k] = {1'b0, a[16*k +: 16]} - {1'b0, b[16*k +: 16]};
    d32 = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    r8  = '0;
    s8  = '0;
    r16 = '0;
    s16 = '0;
    r32 = d32[31:0];
    s32 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r8[8*k +: 8] = d8[k][7:0];
      if (is_signed) begin
        if ((a[8*k+7] != b[8*k+7]) && (d8[k][7] != a[8*k+7])) begin
          s8[k]        = 1'b1;
          r8[8*k +: 8] = a[8*k+7] ? S8_MIN : S8_MAX;
        end
      end else if (d8[k][8]) begin
        s8[k]        = 1'b1;
        r8[8*k +: 8] = '0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      r16[16*k +: 16] = d16[k][15:0];
      if (is_signed) begin
        if ((a[16*k+15] != b[16*k+15]) && (d16[k][15] != a[16*k+15])) begin
          s16[k]          = 1'b1;
          r16[16*k +: 16] = a[16*k+15] ? S16_MIN : S16_MAX;
        end
      end else if (d16[k][16]) begin
        s16[k]          = 1'b1;
        r16[16*k +: 16] = '0;
      end
    end
    if (is_signed) begin
      if ((a[31] != b[31]) && (d32[31] != a[31])) begin
        s32 = 1'b1;
        r32 = a[31] ? S32_MIN : S32_MAX;
      end
    end else if (d32[32]) begin
      s32 = 1'b1;
      r32 = '0;
    end
  end

  always_comb begin
    res   = r32;
    sat_b = {4{s32}};
    case (size)
      SZ_B: begin
        res   = r8;
        sat_b = s8;
      end
      SZ_H: begin
        res   = r16;
        sat_b = {{2{s16[1]}}, {2{s16[0]}}};
      end
      SZ_W, SZ_RSV: begin
        res   = r32;
        sat_b = {4{s32}};
      end
    endcase
  end
endmodule

// File: rtl/vsfx_vsubs_pipe.sv
// Two-stage AltiVec saturating vector subtract (vsubs[bhw]s / vsubu[bhw]s).
// Optional sticky VSCR[SAT] copy enabled by macro VSFX_VSUBS_STICKY_SAT_EN.
module vsfx_vsubs_pipe
  import vsfx_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,  // multiple of 32
  parameter int OPW  = OPW_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  vsfx_vsubs_pipe_if.slave bus,
  input  logic             sat_clr,
  output logic             vscr_sat
);
  localparam int NLANE = VLEN / 32;

  logic            s1_valid;
  logic [OPW-1:0]  s1_op;
  logic [VLEN-1:0] s1_vra;
  logic [VLEN-1:0] s1_vrb;
  logic            s2_valid;
  logic [VLEN-1:0] s2_vrt;
  logic            s2_sat;
  logic            s2_can_load;
  logic [VLEN-1:0]    lane_res;
  logic [4*NLANE-1:0] lane_sat;
  logic               s1_sat;

  assign s2_can_load   = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s2_can_load;
  assign bus.out_valid = s2_valid;
  assign bus.vrt       = s2_vrt;
  assign bus.sat       = s2_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_vra   <= '0;
      s1_vrb   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op  <= bus.op;
        s1_vra <= bus.vra;
        s1_vrb <= bus.vrb;
      end
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    vsfx_sat_sub_lane u_lane (
      .a         (s1_vra[32*g +: 32]),
      .b         (s1_vrb[32*g +: 32]),
      .size      (s1_op[1:0]),
      .is_signed (s1_op[SGN_BIT]),
      .res       (lane_res[32*g +: 32]),
      .sat_b     (lane_sat[4*g +: 4])
    );
  end

  // The reserved size encoding still computes a word result but never flags.
  assign s1_sat = (s1_op[1:0] == SZ_RSV) ? 1'b0 : |lane_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_vrt   <= '0;
      s2_sat   <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_vrt <= lane_res;
        s2_sat <= s1_sat;
      end
    end
  end

`ifdef VSFX_VSUBS_STICKY_SAT_EN
  // A saturating result leaving the unit outranks a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vscr_sat <= 1'b0;
    end else if (s2_valid && bus.out_ready && s2_sat) begin
      vscr_sat <= 1'b1;
    end else if (sat_clr) begin
      vscr_sat <= 1'b0;
    end
  end
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign vscr_sat       = 1'b0;
`endif
endmodule

// File: tb/tb_vsfx_vsubs_pipe.sv
// Self-checking bench for vsfx_vsubs_pipe: scoreboard of expected {sat, vrt}
// from an integer reference model, plus handshake, stall and sticky-flag tasks.
module tb_vsfx_vsubs_pipe;
  import vsfx_pkg::*;

  localparam int VL = VLEN_DEF;
  localparam int W  = VL + 1;

`ifdef VSFX_VSUBS_STICKY_SAT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst;
  logic sat_clr;
  logic vscr_sat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int xfer_cnt = 0;

  logic [W-1:0] exp_q[$];

  vsfx_vsubs_pipe_if bus ();

  vsfx_vsubs_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .sat_clr  (sat_clr),
    .vscr_sat (vscr_sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [VL-1:0] a,
                                         input logic [VL-1:0] b);
    int n;
    logic [VL-1:0] r;
    logic any;
    n   = (o[1:0] == 2'b00) ? 8 : (o[1:0] == 2'b01) ? 16 : 32;
    r   = '0;
    any = 1'b0;
    for (int e = 0; e < VL / n; e++) begin
      logic [63:0] ua, ub;
      longint ea, eb, d, mx, mn;
      ua = 64'((a >> (e * n)) & ((128'(1) << n) - 1));
      ub = 64'((b >> (e * n)) & ((128'(1) << n) - 1));
      ea = longint'(ua);
      eb = longint'(ub);
      if (o[2]) begin
        if (ua[n-1]) ea = ea - (longint'(1) << n);
        if (ub[n-1]) eb = eb - (longint'(1) << n);
        mx = (longint'(1) << (n - 1)) - 1;
        mn = -(longint'(1) << (n - 1));
      end else begin
        mx = (longint'(1) << n) - 1;
        mn = 0;
      end
      d = ea - eb;
      if (d > mx) begin
        d = mx;
        any = 1'b1;
      end else if (d < mn) begin
        d = mn;
        any = 1'b1;
      end
      r = r | ((128'(d) & ((128'(1) << n) - 1)) << (e * n));
    end
    if (o[1:0] == 2'b11) any = 1'b0;
    return {any, r};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] held;
  logic         held_v = 1'b0;

  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got sat=%0b vrt=%h, required no output", bus.sat, bus.vrt);
        end else begin
          e = exp_q.pop_front();
          if ({bus.sat, bus.vrt} !== e)
            begin
              failures++;
              $display("FAIL result: got sat=%0b vrt=%h, required sat=%0b vrt=%h",
                       bus.sat, bus.vrt, e[W-1], e[VL-1:0]);
            end
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (held_v) begin
          checks++;
          if ({bus.sat, bus.vrt} !== held) begin
            failures++;
            $display("FAIL stall_hold: got sat=%0b vrt=%h, required sat=%0b vrt=%h",
                     bus.sat, bus.vrt, held[W-1], held[VL-1:0]);
          end
        end
        held_v = 1'b1;
        held   = {bus.sat, bus.vrt};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] o, input logic [VL-1:0] a, input logic [VL-1:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.vra      = a;
    bus.vrb      = b;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(o, a, b));
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [VL-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    sat_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.vra = '0;
    bus.vrb = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready); end
    if (bus.vrt !== '0)         begin failures++; $display("FAIL reset_vrt: got %h, required 0", bus.vrt); end
    if (bus.sat !== 1'b0)       begin failures++; $display("FAIL reset_sat: got %0b, required 0", bus.sat); end
    if (vscr_sat !== 1'b0)      begin failures++; $display("FAIL reset_vscr_sat: got %0b, required 0", vscr_sat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    send(3'b110, {4{32'd9}}, {4{32'd4}});
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: out_valid=%0b one cycle after accept, required 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL latency_two: out_valid=%0b two cycles after accept, required 1", bus.out_valid); end
    drain();
  endtask

  task automatic test_signed_word();
    send(3'b110, {4{32'h8000_0000}}, {4{32'h0000_0001}});
    send(3'b110, {4{32'd5}}, {4{32'd3}});
    send(3'b110, {4{32'h7FFF_FFFF}}, {4{32'hFFFF_FFFF}});
    drain();
  endtask

  task automatic test_signed_byte();
    send(3'b100, {16{8'h7F}}, {16{8'hFF}});
    send(3'b100, {16{8'h10}}, {16{8'h20}});
    send(3'b100, {8{16'h807F}}, {8{16'h0101}});
    drain();
  endtask

  task automatic test_unsigned_half();
    send(3'b001, {8{16'h0001}}, {8{16'h0002}});
    send(3'b001, {8{16'hFFFF}}, {8{16'h0001}});
    send(3'b000, {16{8'h05}}, {16{8'h06}});
    send(3'b010, {4{32'h0000_0000}}, {4{32'h0000_0001}});
    send(3'b011, {4{32'h0000_0000}}, {4{32'h0000_0001}});
    send(3'b111, {4{32'h8000_0000}}, {4{32'h0000_0001}});
    drain();
  endtask

  task automatic test_back_to_back();
    int c0, x0;
    bus.out_ready = 1'b1;
    c0 = cyc;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++)
      send(3'($urandom_range(0, 7)), rnd128(), rnd128());
    checks++;
    if (cyc - c0 != 8) begin failures++; $display("FAIL b2b_accept_rate: 8 accepts took %0d cycles, required 8", cyc - c0); end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (xfer_cnt - x0 != 8) begin failures++; $display("FAIL b2b_output_rate: %0d results in window, required 8", xfer_cnt - x0); end
    drain();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    send(3'b110, {4{32'h8000_0000}}, {4{32'h0000_0001}});
    send(3'b100, {16{8'h10}}, {16{8'h20}});
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %0b after 2 accepts, required 0", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.op  = 3'b001;
    bus.vra = {8{16'h1234}};
    bus.vrb = {8{16'h0234}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_full: in_ready=%0b out_valid=%0b, required 0/1", bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    send(3'b001, {8{16'h1234}}, {8{16'h0234}});
    send(3'b101, {8{16'h8000}}, {8{16'h7FFF}});
    drain();
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(3'($urandom_range(0, 7)), rnd128(), rnd128());
      end
      begin
        for (int k = 0; k < 70; k++) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_sticky();
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++;
    if (vscr_sat !== 1'b0) begin failures++; $display("FAIL sticky_clear0: got %0b, required 0", vscr_sat); end
    send(3'b100, {16{8'h7F}}, {16{8'hFF}});
    drain();
    checks++;
    if (vscr_sat !== STICKY) begin failures++; $display("FAIL sticky_set: got %0b, required %0b", vscr_sat, STICKY); end
    send(3'b110, {4{32'd5}}, {4{32'd3}});
    drain();
    checks++;
    if (vscr_sat !== STICKY) begin failures++; $display("FAIL sticky_hold: got %0b, required %0b", vscr_sat, STICKY); end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++;
    if (vscr_sat !== 1'b0) begin failures++; $display("FAIL sticky_clear: got %0b, required 0", vscr_sat); end
    sat_clr = 1'b1;
    send(3'b001, {8{16'h0001}}, {8{16'h0002}});
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    sat_clr = 1'b0;
    checks++;
    if (vscr_sat !== STICKY) begin failures++; $display("FAIL sticky_set_wins: got %0b, required %0b", vscr_sat, STICKY); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    send(3'b110, {4{32'h8000_0000}}, {4{32'h0000_0001}});
    send(3'b000, {16{8'h01}}, {16{8'h02}});
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_fill: in_ready=%0b, required 0", bus.in_ready); end
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    checks += 3;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid: got %0b, required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_mid_in_ready: got %0b, required 1", bus.in_ready); end
    if (vscr_sat !== 1'b0)      begin failures++; $display("FAIL rst_mid_vscr_sat: got %0b, required 0", vscr_sat); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale: out_valid=%0b after reset, required 0", bus.out_valid); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_signed_word();
    test_signed_byte();
    test_unsigned_half();
    test_back_to_back();
    test_stall();
    test_random();
    test_sticky();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vsfx_vsubs_pipe.md
Name: vsfx_vsubs_pipe

Overview:
- Pipelined 128-bit AltiVec saturating vector subtract unit (vsubsbs/vsubshs/vsubsws/vsububs/vsubuhs/vsubuws) in the vector simple fixed-point (VSFX) path.
- Computes vrt = vra - vrb per element, clamped to the element range, with a per-operation SAT flag and a sticky VSCR[SAT] copy.
- Two-stage valid/ready pipeline between the VSFX issue stage and the vector register writeback stage.

Parameters:
- VLEN, 128, vector width in bits; must be a multiple of 32.
- OPW, 3, width of the op field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  OPW  op[1:0] element size (00 byte, 01 half, 10 word, 11 reserved); op[2]: 1 signed, 0 unsigned.
- vra  input  VLEN  minuend vector.
- vrb  input  VLEN  subtrahend vector.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- vrt  output  VLEN  saturated difference.
- sat  output  1  1 if any element of this result saturated; qualified by out_valid.
- sat_clr  input  1  clears vscr_sat (software mtvscr).
- vscr_sat  output  1  sticky saturation flag.

Behaviour:
- Reset (rst=1 at an edge): s1_valid=0, s2_valid=0, vrt=0, sat=0, vscr_sat=0. Any in-flight operation is discarded.
- Handshake:
  - Transfer on in_valid&&in_ready and on out_valid&&out_ready.
  - A stage loads when it is empty or its contents are leaving the same cycle.
  - in_ready = !s1_valid || s2_can_load, where s2_can_load = !s2_valid || out_ready.
  - out_valid = s2_valid.
  - vrt and sat hold stable while out_valid=1 and out_ready=0.
  - in_ready may depend combinationally on out_ready. No other combinational input-to-output path.
- Latency: 2 cycles from accept to out_valid. Throughput is 1 per cycle with out_ready held at 1.
- Stage 1:
  - Registers op, vra and vrb.
  - Computes raw lane differences with width N+1 (N = element width); the extra bit captures the borrow in the unsigned case.
- Stage 2: saturates per element and registers vrt and sat.
  - Signed: overflow when the sign of a differs from the sign of b AND the sign of the result differs from the sign of a. Clamp to 2^(N-1)-1 if a is non-negative, else to -2^(N-1).
  - Unsigned: a borrow clamps the element to 0.
  - sat = OR of all element saturation flags.
- op[1:0]=11 is executed as word, and sat is forced to 0 for that result (reserved encoding, no trap).
- vscr_sat:
  - Set on the edge where a result with sat=1 is transferred out (out_valid&&out_ready&&sat).
  - If sat_clr and that set event occur in the same cycle, the set wins (vscr_sat=1).
  - Otherwise sat_clr=1 forces it to 0.
- Stall: with out_ready=0 the pipeline fills two entries, then in_ready=0. No data is lost or duplicated.
- Reset mid-stall clears both stages; out_valid=0 on the next cycle.

Optional Feature:
- Macro VSFX_VSUBS_STICKY_SAT_EN.
- Defined: vscr_sat is the sticky register described above, and sat_clr is honoured.
- Undefined: vscr_sat is tied to 0 and sat_clr is ignored; the per-result sat output is unchanged.

Decomposition:
- Shared package vsfx_pkg:
  - Element-size encodings (SZ_B, SZ_H, SZ_W).
  - Signed-select bit index.
  - VLEN default.
  - Signed max/min constants per size.
- Sub-module vsfx_sat_sub_lane: one 32-bit lane that takes the size and signed controls and produces a 32-bit saturated result plus 4 per-byte sat flags.
  - The top level instantiates VLEN/32 lanes, arranged across the stage-1/stage-2 registers.

Test Plan:
- Signed word: vra lanes = 0x80000000, vrb = 0x00000001, op=110 -> vrt lanes = 0x80000000, sat=1. Then vra=5, vrb=3 -> 0x00000002, sat=0.
- Signed byte: vra bytes = 0x7F, vrb = 0xFF (-1), op=100 -> 0x7F, sat=1. vra=0x10, vrb=0x20 -> 0xF0, sat=0.
- Unsigned half: vra=0x0001, vrb=0x0002, op=001 -> 0x0000, sat=1. vra=0xFFFF, vrb=0x0001 -> 0xFFFE, sat=0.
- Back-to-back with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts.
  - Results then emerge in order, unchanged, and are held stable while stalled.
  - After release, one result per cycle.
- Sticky flag (macro on):
  - A saturating result sets vscr_sat; it stays 1 through non-saturating results.
  - sat_clr clears it.
  - sat_clr coincident with a saturating transfer leaves vscr_sat=1.
  - With the macro off, vscr_sat=0 throughout.
- rst asserted with both stages full: next cycle out_valid=0, in_ready=1, vscr_sat=0. No stale result is emitted.
